mmul_result_serializer: RTL and testbench

- Downstream stage of the mmul matrix multiplier.
- Snapshots the flat result bus C when mmul's `completed` rises.
- Streams the RA*CB elements out one per handshake, row-major, over a valid/ready interface with a last flag.
- Decouples the wide result bus from narrow consumers (FIFO, UART bridge, memory writer).

---
 rtl/mmul_result_serializer_pkg.sv | 14 +
 rtl/mmul_rc_counter.sv | 56 +++++
 rtl/mmul_result_serializer.sv | 121 ++++++++++++
 tb/tb_mmul_result_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_result_serializer_pkg.sv
// Shared types and helpers for the mmul result serializer.
// State encoding and a clog2 helper that never returns zero.
package mmul_result_serializer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmul_rc_counter.sv
// Row/column walker for an RA x CB matrix, row-major order.
// Clear has priority over enable; wraps to (0,0) after the last cell.
module mmul_rc_counter
  import mmul_result_serializer_pkg::*;
#(
  parameter int RA = 2,
  parameter int CB = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [clog2_min1(RA)-1:0] row_o,
  output logic [clog2_min1(CB)-1:0] col_o,
  output logic                      last_o
);

  localparam int RW = clog2_min1(RA);
  localparam int CW = clog2_min1(CB);
  localparam logic [RW-1:0] RMAX = RW'(RA - 1);
  localparam logic [CW-1:0] CMAX = CW'(CB - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == CMAX) begin
        col_d = '0;
        row_d = (row_q == RMAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == RMAX) && (col_q == CMAX);

endmodule

// File: rtl/mmul_result_serializer.sv
// Snapshots mmul's flat result bus and streams it row-major.
// MMUL_SER_INDEX_EN adds out_row/out_col element coordinates.
module mmul_result_serializer
  import mmul_result_serializer_pkg::*;
#(
  parameter int RA = 2,
  parameter int CB = 2,
  parameter int W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RA*CB*W-1:0]        C,
  input  logic                      completed,
  output logic [W-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
`ifdef MMUL_SER_INDEX_EN
  output logic [clog2_min1(RA)-1:0] out_row,
  output logic [clog2_min1(CB)-1:0] out_col,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int N  = RA * CB;
  localparam int IW = clog2_min1(N);
  localparam int RW = clog2_min1(RA);
  localparam int CW = clog2_min1(CB);

  ser_state_e state_q, state_d;
  logic [N*W-1:0] snap_q, snap_d;
  logic cmp_q;
  logic ovr_q, ovr_d;
  logic done_q, done_d;

  logic          rise, xfer, valid;
  logic          cnt_clr, cnt_en, cnt_last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] idx;

  mmul_rc_counter #(
    .RA(RA),
    .CB(CB)
  ) u_rc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .row_o (row),
    .col_o (col),
    .last_o(cnt_last)
  );

  assign idx   = IW'(row) * IW'(CB) + IW'(col);
  assign rise  = completed & ~cmp_q;
  assign valid = (state_q == ST_STREAM);
  assign xfer  = valid & out_ready;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          snap_d  = C;
          cnt_clr = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer && cnt_last) begin
          done_d  = 1'b1;
          cnt_clr = 1'b1;
          // A completion landing on the final handshake restarts seamlessly
          if (rise) snap_d = C;
          else state_d = ST_IDLE;
        end else begin
          cnt_en = xfer;
          if (rise) ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      cmp_q   <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cmp_q   <= completed;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid;
  assign out_data  = valid ? snap_q[W*idx +: W] : '0;
  assign out_last  = valid & cnt_last;
  assign busy      = valid;
  assign done      = done_q;
  assign overrun   = ovr_q;

`ifdef MMUL_SER_INDEX_EN
  assign out_row = valid ? row : '0;
  assign out_col = valid ? col : '0;
`endif

endmodule

// File: tb/tb_mmul_result_serializer.sv
// Scoreboard bench for mmul_result_serializer (RA=2, CB=2, W=8).
module tb_mmul_result_serializer;

  localparam int RA = 2;
  localparam int CB = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     C;
  logic            completed;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overrun;
`ifdef MMUL_SER_INDEX_EN
  logic            out_row;
  logic            out_col;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];
  logic       prev_lastx = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  always #5 clk = ~clk;

  mmul_result_serializer #(
    .RA(RA),
    .CB(CB),
    .W (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .C        (C),
    .completed(completed),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
`ifdef MMUL_SER_INDEX_EN
    .out_row  (out_row),
    .out_col  (out_col),
`endif
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] m);
    for (int i = 0; i < RA * CB; i++)
      exp_q.push_back({i == RA * CB - 1, m[8*i +: 8]});
  endtask

  // Monitor current outputs against the inputs about to be sampled, then advance
  task automatic cyc();
    logic [8:0] e;
    chk("done", done, prev_lastx);
    if (done) done_cnt++;
    if (prev_stall && !rst) chk("stable", {out_last, out_data}, prev_out);
    if (!out_valid) chk("idle_zero", {out_last, out_data}, 9'h0);
    prev_lastx = 1'b0;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", out_data, e[7:0]);
        chk("last", out_last, e[8]);
        prev_lastx = out_last;
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_out = {out_last, out_data};
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    C = 32'h04030201;
    completed = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);

    // basic drain
    out_ready = 1'b1;
    completed = 1'b1;
    push(C);
    cyc();
    chk("latency", out_valid, 1);
    chk("busy_on", busy, 1);
    done_cnt = 0;
    drain(6);
    chk("basic_empty", exp_q.size(), 0);
    chk("basic_done", done_cnt, 1);
    chk("busy_off", busy, 0);
    completed = 1'b0;
    cyc();

    // backpressure 1,0,0,1,...
    completed = 1'b1;
    push(C);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      cyc();
    end
    chk("bp_empty", exp_q.size(), 0);
    chk("bp_done", done_cnt, 1);
    completed = 1'b0;
    out_ready = 1'b1;
    cyc();

    // snapshot isolation
    completed = 1'b1;
    push(C);
    cyc();
    cyc();
    C = 32'hAAAAAAAA;
    completed = 1'b0;
    drain(5);
    chk("iso_empty", exp_q.size(), 0);
    C = 32'h04030201;

    // overrun
    completed = 1'b1;
    push(C);
    cyc();
    cyc();
    cyc();
    out_ready = 1'b0;
    completed = 1'b0;
    cyc();
    completed = 1'b1;
    cyc();
    chk("ovr_set", overrun, 1);
    out_ready = 1'b1;
    drain(5);
    chk("ovr_empty", exp_q.size(), 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_idle", out_valid, 0);
    completed = 1'b0;
    do_reset();
    chk("ovr_clr", overrun, 0);

    // seamless restart on the final handshake
    completed = 1'b1;
    push(C);
    cyc();
    completed = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("sl_last", out_last, 1);
    completed = 1'b1;
    C = 32'h08070605;
    push(C);
    cyc();
    chk("sl_nogap", out_valid, 1);
    chk("sl_done", done, 1);
    drain(6);
    chk("sl_empty", exp_q.size(), 0);
    chk("sl_ovr", overrun, 0);
    completed = 1'b0;
    C = 32'h04030201;
    cyc();

    // reset mid-stream
    completed = 1'b1;
    push(C);
    cyc();
    completed = 1'b0;
    cyc();
    do_reset();
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    cyc();
    completed = 1'b1;
    push(C);
    cyc();
    chk("mr_first", out_data, 8'h01);
    drain(6);
    chk("mr_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
